ex_stage_md: RTL
================

Name: ex_stage_md

Overview:
- Parametrised next-generation MIPS execute stage.
- Contains operand forwarding muxes, ALU-source and register-destination selection, and a branch-target adder.
- Adds HI/LO registers, an iterative multiply/divide unit with a ready/stall handshake, and a registered EX/MEM output.
- Sits between the ID/EX register and the MEM stage; the hazard unit consumes ready_o to freeze upstream stages.

Parameters:
- DATA_W, 32, datapath width (even, ≥8).
- REG_AW, 5, register-index width.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  ID/EX holds a live instruction.
- ready_o  out  1  stage can accept; 0 while multiply/divide is busy.
- flush_i  in  1  kill the incoming instruction.
- op_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MFHI, 13 MFLO, 14 MTHI, 15 MTLO.
- rs_data_i, rt_data_i  in  DATA_W  register-file operands.
- fwd_ex_i, fwd_wb_i  in  DATA_W  forwarded EX/MEM result and WB data.
- fwd_a_i, fwd_b_i  in  2  operand select: 0 regfile, 1 fwd_ex, 2 fwd_wb, 3 zero.
- imm_i  in  DATA_W  sign-extended immediate.
- alusrc_i  in  1  operand B: 0 forwarded rt, 1 imm_i.
- rt_i, rd_i  in  REG_AW  destination candidates.
- regdst_i  in  1  destination: 0 rt_i, 1 rd_i.
- pc_plus4_i  in  DATA_W  PC+4 of the instruction.
- valid_o  out  1  registered result valid.
- we_o  out  1  result is to be written to the register file.
- result_o  out  DATA_W  registered ALU/MF result.
- zero_o  out  1  registered result == 0.
- wdst_o  out  REG_AW  registered destination.
- store_data_o  out  DATA_W  registered forwarded B, taken before the alusrc mux.
- branch_tgt_o  out  DATA_W  registered pc_plus4_i + (imm_i << 2), modulo 2^DATA_W.

Behaviour:
- Reset: all outputs 0 except ready_o = 1; HI = LO = 0; FSM in IDLE; counter 0.
- Accept condition: valid_i & ready_o & ~flush_i. An instruction not accepted has no effect.
- ALU ops 0–7: 1-cycle latency; outputs registered at the next edge with valid_o = 1, we_o = 1.
- SLT compares signed; SLTU compares unsigned.
- Arithmetic wraps modulo 2^DATA_W; no overflow trap.
- MFHI / MFLO: result is HI / LO; we_o = 1.
- MTHI / MTLO: write forwarded A into HI / LO at the accept edge; valid_o = 1, we_o = 0.
- Every cycle without an accept produces valid_o = 0 and we_o = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: accepting ops 8–11 latches operand magnitudes and signs, clears the counter, goes to BUSY. valid_o = 0 for that op; an MD op never writes the register file.
- BUSY: one iteration per cycle, ready_o = 0.
  - Multiply: shift-add, producing a 2·DATA_W product.
  - Divide: restoring, producing quotient and remainder.
  - After exactly DATA_W cycles, go to DONE.
- DONE (1 cycle, ready_o = 0): apply sign correction; write HI/LO; return to IDLE.
- Timing: accept at edge k → HI/LO valid and ready_o = 1 in cycle k + DATA_W + 2.
- Result placement: MULT/MULTU put the high half in HI and the low half in LO. DIV/DIVU put the quotient in LO and the remainder in HI.
- Signed divide: quotient truncates toward 0; remainder takes the dividend's sign.
- -2^(DATA_W-1) / -1: LO = -2^(DATA_W-1), HI = 0.
- Divide by zero, signed or unsigned: LO = all ones, HI = dividend; still takes the full latency.
- flush_i during BUSY/DONE does not abort the in-flight MD op. flush_i only blocks acceptance of the current input.
- rst_i mid-operation aborts to IDLE and clears HI/LO.
- MF/MT or a second MD op presented while busy waits because ready_o = 0; upstream must hold its inputs stable.
- Forwarding and branch-target paths are combinational into the output register; select 3 yields 0.

Optional Feature:
- Macro EX_FAST_MUL_EN.
- Defined: MULT/MULTU compute combinationally and write HI/LO at the accept edge; no BUSY/DONE and ready_o stays 1. MFHI accepted in the next cycle sees the product. DIV/DIVU are unchanged.
- Undefined: iterative multiply as described under Behaviour.

Test Plan:
- ADD, rs = 5 fwd 0, rt fwd_ex = 7, alusrc 0 → next cycle result_o = 12, zero_o = 0, valid_o = we_o = 1, wdst_o = rd_i.
- SUB with imm_i = 0xFFFFFFFC, pc_plus4_i = 0x100, alusrc 1, rs = 0xFFFFFFFC → result_o = 0, zero_o = 1, branch_tgt_o = 0xF0.
- MULT 0xFFFFFFFE × 3 → ready_o low for 33 cycles; then MFHI = 0xFFFFFFFF, MFLO = 0xFFFFFFFA. With EX_FAST_MUL_EN: ready_o never drops, same values.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 9 / 0 → LO = 0xFFFFFFFF, HI = 9.
- rst_i asserted at BUSY cycle 10 → next cycle ready_o = 1; MFHI returns 0.
- flush_i with valid_i on an ADD → valid_o = 0 next cycle. flush_i during BUSY → MD op still completes and HI/LO update.

Source files
------------

// File: rtl/ex_stage_md.sv
// ex_stage_md
// MIPS execute stage with forwarding muxes, ALU-source and destination
// selection, branch-target adder, HI/LO registers, an iterative
// multiply/divide unit and a registered EX/MEM output.
//
// Build option: EX_FAST_MUL_EN -- when defined, MULT/MULTU complete
// combinationally at the accept edge. Only DIV/DIVU use the iterative unit.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   valid_i / ready_o          input handshake; ready_o low while MD busy
//   flush_i                    blocks acceptance of the current input
//   op_i                       operation code (ALU, MD, MF/MT)
//   rs_data_i, rt_data_i       register-file operands
//   fwd_ex_i, fwd_wb_i         forwarded EX/MEM and WB data
//   fwd_a_i, fwd_b_i           operand select: regfile/ex/wb/zero
//   imm_i, alusrc_i            immediate and operand-B source select
//   rt_i, rd_i, regdst_i       destination candidates and select
//   pc_plus4_i                 PC+4 for the branch-target adder
//   valid_o, we_o, result_o, zero_o, wdst_o, store_data_o, branch_tgt_o
//                              registered EX/MEM outputs
//
// state  | meaning
// S_IDLE | accepting instructions; MD ops start here
// S_BUSY | one multiply/divide iteration per cycle, DATA_W cycles
// S_DONE | sign correction and HI/LO write, then back to S_IDLE
module ex_stage_md #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] fwd_ex_i,
    input  logic [DATA_W-1:0] fwd_wb_i,
    input  logic [1:0]        fwd_a_i,
    input  logic [1:0]        fwd_b_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic              alusrc_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              regdst_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    output logic              valid_o,
    output logic              we_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic [REG_AW-1:0] wdst_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [DATA_W-1:0] branch_tgt_o
);
    localparam int W = DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    state_e state_q, state_d;

    logic [W-1:0]     op_a, op_b_fwd, op_b, alu_res;
    logic             accept, is_md_op, is_mul, signed_op, md_start;
    logic [W-1:0]     mag_a, mag_b;
    logic [W-1:0]     hi_q, lo_q;
    logic [W-1:0]     acc_q, wrk_q, mb_q, dvd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mul_q, sa_q, sb_q, div0_q;
    logic [W:0]       mul_sum, div_shift, div_trial;
    logic [W-1:0]     acc_step, wrk_step;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     quo_fix, rem_fix;

    assign ready_o   = (state_q == S_IDLE);
    assign accept    = valid_i & ready_o & ~flush_i;
    assign is_md_op  = (op_i[3:2] == 2'b10);
    assign is_mul    = is_md_op & ~op_i[1];
    assign signed_op = ~op_i[0];

`ifdef EX_FAST_MUL_EN
    logic [2*W-1:0] fast_prod;
    logic           fast_mul;
    assign fast_prod = {{W{signed_op & op_a[W-1]}}, op_a}
                     * {{W{signed_op & op_b_fwd[W-1]}}, op_b_fwd};
    assign fast_mul  = accept & is_mul;
    assign md_start  = accept & is_md_op & ~is_mul;
`else
    assign md_start  = accept & is_md_op;
`endif

    always_comb begin
        case (fwd_a_i)
            2'd0:    op_a = rs_data_i;
            2'd1:    op_a = fwd_ex_i;
            2'd2:    op_a = fwd_wb_i;
            default: op_a = '0;
        endcase
        case (fwd_b_i)
            2'd0:    op_b_fwd = rt_data_i;
            2'd1:    op_b_fwd = fwd_ex_i;
            2'd2:    op_b_fwd = fwd_wb_i;
            default: op_b_fwd = '0;
        endcase
        op_b = alusrc_i ? imm_i : op_b_fwd;
    end

    always_comb begin
        alu_res = '0;
        case (op_i)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = ~(op_a | op_b);
            4'd6:    alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd7:    alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
            4'd12:   alu_res = hi_q;
            4'd13:   alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // MD operands are rs and the forwarded rt, never the immediate.
    assign mag_a = (signed_op & op_a[W-1])     ? -op_a     : op_a;
    assign mag_b = (signed_op & op_b_fwd[W-1]) ? -op_b_fwd : op_b_fwd;

    // Multiply: acc_q is the running high half, wrk_q the multiplier that
    // shifts out as product low bits shift in. Divide: {acc_q, wrk_q}
    // is the remainder/dividend pair, quotient bits enter wrk_q from the right.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, mb_q} : {(W+1){1'b0}});
        div_shift = {acc_q, wrk_q[W-1]};
        div_trial = div_shift - {1'b0, mb_q};
        if (mul_q) begin
            acc_step = mul_sum[W:1];
            wrk_step = {mul_sum[0], wrk_q[W-1:1]};
        end else if (!div_trial[W]) begin
            acc_step = div_trial[W-1:0];
            wrk_step = {wrk_q[W-2:0], 1'b1};
        end else begin
            acc_step = div_shift[W-1:0];
            wrk_step = {wrk_q[W-2:0], 1'b0};
        end
        prod_fix = (sa_q ^ sb_q) ? -{acc_q, wrk_q} : {acc_q, wrk_q};
        quo_fix  = (sa_q ^ sb_q) ? -wrk_q : wrk_q;
        rem_fix  = sa_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (md_start) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == CNT_W'(W - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o      <= 1'b0;
            we_o         <= 1'b0;
            result_o     <= '0;
            zero_o       <= 1'b0;
            wdst_o       <= '0;
            store_data_o <= '0;
            branch_tgt_o <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            acc_q        <= '0;
            wrk_q        <= '0;
            mb_q         <= '0;
            dvd_q        <= '0;
            cnt_q        <= '0;
            mul_q        <= 1'b0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            div0_q       <= 1'b0;
        end else begin
            valid_o <= accept & ~is_md_op;
            we_o    <= accept & (~op_i[3] | (op_i[3:1] == 3'b110));
            if (accept) begin
                result_o     <= alu_res;
                zero_o       <= (alu_res == '0);
                wdst_o       <= regdst_i ? rd_i : rt_i;
                store_data_o <= op_b_fwd;
                branch_tgt_o <= pc_plus4_i + (imm_i << 2);
                if (op_i == 4'd14) hi_q <= op_a;
                if (op_i == 4'd15) lo_q <= op_a;
            end
`ifdef EX_FAST_MUL_EN
            if (fast_mul) begin
                hi_q <= fast_prod[2*W-1:W];
                lo_q <= fast_prod[W-1:0];
            end
`endif
            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        mul_q  <= is_mul;
                        sa_q   <= signed_op & op_a[W-1];
                        sb_q   <= signed_op & op_b_fwd[W-1];
                        div0_q <= (op_b_fwd == '0);
                        dvd_q  <= op_a;
                        wrk_q  <= mag_a;
                        mb_q   <= mag_b;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_step;
                    wrk_q <= wrk_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_DONE: begin
                    if (mul_q) begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end else if (div0_q) begin
                        hi_q <= dvd_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
